// File: rtl/uart_tx_sequencer.sv
// UART transmit frame sequencer: start, data, optional parity, stop bits.
// One-byte holding register lets frames run back to back with no idle gap.
module uart_tx_sequencer #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1,
    parameter int IDX_W        = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 done,
    output logic [IDX_W-1:0]     bit_index
);

    localparam int FRAME_BITS = 1 + DATA_BITS + PARITY_EN + STOP_BITS;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_DLAST = IDX_W'(DATA_BITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_BITS - 1);
    localparam logic PAR_INV = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [IDX_W-1:0]     idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic [DATA_BITS-1:0] hold, hold_n;
    logic                 hold_full, hold_full_n;
    logic                 par, par_n;
    logic                 tx_n, busy_n, done_n;
    logic                 accept, boundary;

    assign tx_ready = !rst && ((state == IDLE) || !hold_full);
    assign accept   = tx_valid && tx_ready;
    assign boundary = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_index <= '0;
            shreg     <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            par       <= 1'b0;
            tx        <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_index <= idx_n;
            shreg     <= shreg_n;
            hold      <= hold_n;
            hold_full <= hold_full_n;
            par       <= par_n;
            tx        <= tx_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = boundary ? '0 : cnt + 1'b1;
        idx_n       = bit_index;
        shreg_n     = shreg;
        hold_n      = hold;
        hold_full_n = hold_full;
        par_n       = par;
        tx_n        = tx;
        busy_n      = busy;
        done_n      = 1'b0;

        // Mid-frame accepts park in the hold register; bypass overrides below
        if (accept && state != IDLE) begin
            hold_n      = tx_data;
            hold_full_n = 1'b1;
        end

        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (accept) begin
                    shreg_n = tx_data;
                    par_n   = ^tx_data;
                    state_n = START;
                    tx_n    = 1'b0;
                    busy_n  = 1'b1;
                    idx_n   = '0;
                end
            end
            START: begin
                if (boundary) begin
                    state_n = DATA;
                    idx_n   = bit_index + 1'b1;
                    tx_n    = shreg[0];
                    shreg_n = shreg >> 1;
                end
            end
            DATA: begin
                if (boundary) begin
                    idx_n = bit_index + 1'b1;
                    if (bit_index == IDX_DLAST) begin
                        if (PARITY_EN != 0) begin
                            state_n = PARITY;
                            tx_n    = par ^ PAR_INV;
                        end else begin
                            state_n = STOP;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        tx_n    = shreg[0];
                        shreg_n = shreg >> 1;
                    end
                end
            end
            PARITY: begin
                if (boundary) begin
                    state_n = STOP;
                    idx_n   = bit_index + 1'b1;
                    tx_n    = 1'b1;
                end
            end
            STOP: begin
                if (boundary && bit_index == IDX_LAST) begin
                    done_n = 1'b1;
                    idx_n  = '0;
                    if (hold_full) begin
                        shreg_n     = hold;
                        par_n       = ^hold;
                        hold_full_n = 1'b0;
                        state_n     = START;
                        tx_n        = 1'b0;
                    end else if (accept) begin
                        shreg_n     = tx_data;
                        par_n       = ^tx_data;
                        hold_n      = hold;
                        hold_full_n = 1'b0;
                        state_n     = START;
                        tx_n        = 1'b0;
                    end else begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                        tx_n    = 1'b1;
                    end
                end else if (boundary) begin
                    idx_n = bit_index + 1'b1;
                    tx_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Scoreboard bench for uart_tx_sequencer: 8N1 and 8O2 instances,
// expected frames queued on accept, checked by a line-decoding monitor.
module tb_uart_tx_sequencer;

    localparam int C = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]      tv, rdy, txl, bsy, dn;
    logic [1:0][7:0] td;
    logic [1:0][3:0] bi;

    int n_checks = 0;
    int n_fail = 0;
    logic [15:0] q0[$];
    logic [15:0] q1[$];

    int          mcyc[2];
    bit          inf[2];
    logic [15:0] gotf[2];
    int          b2b[2];

    uart_tx_sequencer #(
        .DATA_BITS(8), .CLKS_PER_BIT(C), .PARITY_EN(0),
        .PARITY_ODD(0), .STOP_BITS(1), .IDX_W(4)
    ) u0 (
        .clk(clk), .rst(rst), .tx_data(td[0]), .tx_valid(tv[0]),
        .tx_ready(rdy[0]), .tx(txl[0]), .busy(bsy[0]),
        .done(dn[0]), .bit_index(bi[0])
    );

    uart_tx_sequencer #(
        .DATA_BITS(8), .CLKS_PER_BIT(C), .PARITY_EN(1),
        .PARITY_ODD(1), .STOP_BITS(2), .IDX_W(4)
    ) u1 (
        .clk(clk), .rst(rst), .tx_data(td[1]), .tx_valid(tv[1]),
        .tx_ready(rdy[1]), .tx(txl[1]), .busy(bsy[1]),
        .done(dn[1]), .bit_index(bi[1])
    );

    function automatic int fbits(input int id);
        return (id == 0) ? 10 : 12;
    endfunction

    // Line image of one frame, bit i of the result = i-th bit on the wire
    function automatic logic [15:0] frame_of(input int id, input logic [7:0] b);
        logic [15:0] f;
        int n;
        f = '0;
        n = 1;
        for (int i = 0; i < 8; i++) begin
            f[n] = b[i];
            n++;
        end
        if (id == 1) begin
            f[n] = ~(^b);
            n++;
        end
        for (int i = n; i < fbits(id); i++) f[i] = 1'b1;
        return f;
    endfunction

    task automatic check(input string name, input logic [15:0] got,
                         input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic push(input int id, input logic [7:0] b);
        if (id == 0) q0.push_back(frame_of(0, b));
        else q1.push_back(frame_of(1, b));
    endtask

    task automatic mon(input int id);
        int F;
        int qs;
        logic [15:0] e;
        F = fbits(id);
        if (rst) begin
            inf[id] = 0;
            return;
        end
        qs = (id == 0) ? q0.size() : q1.size();
        if (inf[id]) begin
            if (mcyc[id] < F * C) begin
                if (mcyc[id] % C == C / 2) begin
                    gotf[id][mcyc[id] / C] = txl[id];
                    check("bit_index", 16'(bi[id]), 16'(mcyc[id] / C));
                    check("busy_in_frame", 16'(bsy[id]), 16'd1);
                    check("done_in_frame", 16'(dn[id]), 16'd0);
                end
                mcyc[id]++;
            end else begin
                check("done_pulse", 16'(dn[id]), 16'd1);
                check("bit_index_wrap", 16'(bi[id]), 16'd0);
                if (qs == 0) begin
                    check("frame_expected", 16'(qs), 16'd1);
                end else begin
                    e = (id == 0) ? q0.pop_front() : q1.pop_front();
                    check("frame", gotf[id], e);
                    qs--;
                end
                check("next_start_tx", 16'(txl[id]), 16'(qs == 0));
                check("busy_at_done", 16'(bsy[id]), 16'(qs > 0));
                inf[id] = (qs > 0);
                mcyc[id] = 1;
                gotf[id] = '0;
                if (qs > 0) b2b[id]++;
            end
        end else begin
            check("idle_outputs", 16'({dn[id], bsy[id], txl[id], bi[id]}),
                  (qs > 0) ? 16'b0100000 : 16'b0010000);
            if (qs > 0) begin
                inf[id] = 1;
                mcyc[id] = 1;
                gotf[id] = '0;
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    // Entered and left at posedge+1; acceptance decided just before the edge
    task automatic step(input logic [1:0] v, input logic [7:0] d0,
                        input logic [7:0] d1, output logic [1:0] acc);
        tv = v;
        td[0] = d0;
        td[1] = d1;
        @(negedge clk);
        acc = v & rdy;
        @(posedge clk);
        if (acc[0]) push(0, d0);
        if (acc[1]) push(1, d1);
        #1;
    endtask

    task automatic idle(input int n);
        logic [1:0] a;
        repeat (n) step(2'b00, 8'h00, 8'h00, a);
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while ((q0.size() != 0 || q1.size() != 0 || bsy != 0) && k < budget) begin
            idle(1);
            k++;
        end
        check("drain_timeout", 16'(k >= budget), 16'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] a, pend;
        logic [7:0] r, pd0, pd1;
        logic [7:0] d6[3];
        int k, base;

        tv = 2'b00;
        td = '0;
        b2b[0] = 0;
        b2b[1] = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 16'(rdy), 16'd0);
        check("rst_tx", 16'(txl), 16'b11);
        check("rst_busy_done", 16'({bsy, dn}), 16'd0);
        check("rst_bit_index", 16'(bi), 16'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 16'(rdy), 16'b11);
        @(posedge clk);
        #1;

        // Single 8N1 frame
        step(2'b01, 8'hA5, 8'h00, a);
        check("t1_accept", 16'(a[0]), 16'd1);
        idle(39);
        check("t1_done_early", 16'(dn[0]), 16'd0);
        idle(1);
        check("t1_done_40", 16'(dn[0]), 16'd1);
        idle(2);
        check("t1_busy_after", 16'(bsy[0]), 16'd0);

        // Back-to-back through the hold register
        base = b2b[0];
        step(2'b01, 8'h55, 8'h00, a);
        idle(10);
        step(2'b01, 8'h0F, 8'h00, a);
        check("t2_accept_mid", 16'(a[0]), 16'd1);
        check("t2_ready_drop", 16'(rdy[0]), 16'd0);
        drain(300);
        check("t2_b2b", 16'(b2b[0] - base), 16'd1);

        // Bypass on the final stop boundary
        base = b2b[0];
        r = 8'($urandom);
        step(2'b01, r, 8'h00, a);
        idle(39);
        step(2'b01, 8'h3C, 8'h00, a);
        check("t3_bypass_accept", 16'(a[0]), 16'd1);
        check("t3_no_gap", 16'({dn[0], bsy[0], txl[0]}), 16'b110);
        drain(300);
        check("t3_b2b", 16'(b2b[0] - base), 16'd1);

        // Odd parity, two stop bits
        step(2'b10, 8'h00, 8'h07, a);
        check("t4_accept", 16'(a[1]), 16'd1);
        idle(47);
        check("t4_done_early", 16'(dn[1]), 16'd0);
        idle(1);
        check("t4_done_48", 16'(dn[1]), 16'd1);
        drain(300);

        // Reset during data bit 3 with the hold register full
        step(2'b01, 8'($urandom), 8'h00, a);
        step(2'b01, 8'($urandom), 8'h00, a);
        check("t5_hold_accept", 16'(a[0]), 16'd1);
        k = 0;
        while (bi[0] != 4'd4 && k < 100) begin
            idle(1);
            k++;
        end
        check("t5_reach_bit3", 16'(bi[0]), 16'd4);
        check("t5_hold_full", 16'(rdy[0]), 16'd0);
        rst = 1'b1;
        tv = 2'b00;
        q0.delete();
        q1.delete();
        @(negedge clk);
        check("t5_ready_in_rst", 16'(rdy[0]), 16'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t5_reset_out", 16'({txl[0], bsy[0], dn[0], bi[0]}), 16'b1000000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("t5_ready_after", 16'(rdy[0]), 16'd1);
        @(posedge clk);
        #1;
        idle(100);

        // Source holding valid high across three bytes
        base = b2b[0];
        d6[0] = 8'($urandom);
        d6[1] = d6[0] + 8'd1;
        d6[2] = d6[0] + 8'd2;
        for (int j = 0; j < 3; j++) begin
            k = 0;
            a = 2'b00;
            while (!a[0] && k < 200) begin
                step(2'b01, d6[j], 8'h00, a);
                k++;
            end
            check("t6_accept", 16'(a[0]), 16'd1);
        end
        drain(400);
        check("t6_b2b", 16'(b2b[0] - base), 16'd2);

        // Random traffic on both instances
        pend = 2'b00;
        pd0 = 8'h00;
        pd1 = 8'h00;
        for (int c = 0; c < 1500; c++) begin
            if (!pend[0] && $urandom_range(0, 9) == 0) begin
                pend[0] = 1'b1;
                pd0 = 8'($urandom);
            end
            if (!pend[1] && $urandom_range(0, 9) == 0) begin
                pend[1] = 1'b1;
                pd1 = 8'($urandom);
            end
            step(pend, pd0, pd1, a);
            pend = pend & ~a;
        end
        drain(500);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
